// File: rtl/bch_pkg.sv
// Shared BCH(255,191,t=8) field definitions and GF(2^8) helpers for the
// encoder/syndrome/locator chain.
package bch_pkg;

   localparam int unsigned N     = 255;
   localparam int unsigned K     = 191;
   localparam int unsigned T     = 8;
   localparam int unsigned M     = 8;
   localparam int unsigned NSYN  = 2 * T;
   localparam int unsigned CNT_W = 8;

   localparam logic [M:0] PRIM_POLY = 9'h11D;

   // Multiply by alpha (x) and reduce modulo PRIM_POLY.
   function automatic logic [M-1:0] gf_xtime(input logic [M-1:0] x);
      return {x[M-2:0], 1'b0} ^ (PRIM_POLY[M-1:0] & {M{x[M-1]}});
   endfunction

   // x * alpha^j; j is a constant at every RTL call site, so this folds to XORs.
   function automatic logic [M-1:0] gf_mul_const(input logic [M-1:0] x,
                                                 input int unsigned j);
      logic [M-1:0] r;
      r = x;
      for (int unsigned i = 0; i < j; i++) r = gf_xtime(r);
      return r;
   endfunction

   // General shift-and-add multiplier, not used in the datapath.
   function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                           input logic [M-1:0] b);
      logic [M-1:0] r;
      logic [M-1:0] p;
      r = '0;
      p = a;
      for (int unsigned i = 0; i < M; i++) begin
         if (b[i]) r = r ^ p;
         p = gf_xtime(p);
      end
      return r;
   endfunction

   function automatic logic [(NSYN+1)*M-1:0] build_alpha_tab();
      logic [(NSYN+1)*M-1:0] tab;
      tab = '0;
      for (int unsigned j = 0; j <= NSYN; j++)
         tab[j*M +: M] = gf_mul_const(M'(1), j);
      return tab;
   endfunction

   // alpha^j in bits [j*M +: M], j = 0..2T.
   localparam logic [(NSYN+1)*M-1:0] ALPHA_TAB = build_alpha_tab();

endpackage

// File: rtl/bch_syn_cell.sv
// One Horner syndrome register: S <= S*alpha^J + b per enabled cycle.
module bch_syn_cell
   import bch_pkg::*;
#(
   parameter int unsigned J = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic         b,
   output logic [M-1:0] s,
   output logic [M-1:0] s_nxt_c
);

   assign s_nxt_c = gf_mul_const(s, J) ^ {{(M-1){1'b0}}, b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      s <= '0;
      else if (clr) s <= '0;
      else if (en)  s <= s_nxt_c;
   end

endmodule

// File: rtl/bch_syndrome.sv
// Bit-serial BCH(255,191) syndrome generator: evaluates r(x) at alpha^1..alpha^16,
// MSB (x^254) first, one codeword bit per clock.
module bch_syndrome
   import bch_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [N-1:0]      codeword,
   output logic              ready,
   output logic              done,
   output logic [NSYN*M-1:0] syndromes,
   output logic              error
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic               load_c;
   logic               busy_c;
   logic [N-1:0]       shreg;
   logic [CNT_W-1:0]   cnt;
   logic [M-1:0]       syn_nxt_c [NSYN];
   logic               err_nxt_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_c    = 1'b0;
      unique case (state)
         IDLE: if (start) begin
            state_nxt = BUSY;
            load_c    = 1'b1;
         end
         BUSY: if (cnt == CNT_W'(N - 1)) state_nxt = DONE;
         DONE: begin
            load_c    = start;
            state_nxt = start ? BUSY : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy_c = (state == BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load_c) begin
         shreg <= codeword;
         cnt   <= '0;
      end else if (busy_c) begin
         shreg <= {shreg[N-2:0], 1'b0};
         cnt   <= cnt + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < NSYN; g++) begin : g_cell
      bch_syn_cell #(.J(g + 1)) u_cell (
         .clk     (clk),
         .clr     (load_c),
         .rst     (rst),
         .en      (busy_c),
         .b       (shreg[N-1]),
         .s       (syndromes[g*M +: M]),
         .s_nxt_c (syn_nxt_c[g])
      );
   end

   // Error flag looks at the values being written on the final bit edge.
   always_comb begin
      err_nxt_c = 1'b0;
      for (int unsigned g = 0; g < NSYN; g++) err_nxt_c = err_nxt_c | (|syn_nxt_c[g]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready <= 1'b1;
         done  <= 1'b0;
         error <= 1'b0;
      end else begin
         ready <= (state_nxt != BUSY);
         done  <= busy_c && (state_nxt == DONE);
         if (load_c)                             error <= 1'b0;
         else if (busy_c && state_nxt == DONE)   error <= err_nxt_c;
      end
   end

endmodule

// File: tb/tb_bch_syndrome.sv
// Directed bench for bch_syndrome: hand-derived syndromes plus a power-sum model.
module tb_bch_syndrome;
   import bch_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [N-1:0]      codeword;
   logic              ready;
   logic              done;
   logic [NSYN*M-1:0] syndromes;
   logic              error;

   int n_cmp = 0;
   int n_bad = 0;
   logic [M-1:0] alog [N];

   bch_syndrome dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .codeword  (codeword),
      .ready     (ready),
      .done      (done),
      .syndromes (syndromes),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // S_j = sum over set bits i of alpha^(j*i), evaluated directly.
   function automatic logic [NSYN*M-1:0] model(input logic [N-1:0] cw);
      logic [NSYN*M-1:0] r;
      r = '0;
      for (int j = 1; j <= int'(NSYN); j++)
         for (int i = 0; i < int'(N); i++)
            if (cw[i]) r[(j-1)*M +: M] = r[(j-1)*M +: M] ^ alog[(j * i) % int'(N)];
      return r;
   endfunction

   // Starts a word from the low clock phase; returns cycles to done and ready violations.
   task automatic run_word(input logic [N-1:0] cw, input int pulse_at,
                           input logic [N-1:0] pulse_cw,
                           output int lat, output int ready_bad);
      lat = 0;
      ready_bad = 0;
      start = 1'b1;
      codeword = cw;
      @(posedge clk);
      #1 start = 1'b0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
         if (ready !== 1'b0) ready_bad++;
         if (k == pulse_at) begin
            start = 1'b1;
            codeword = pulse_cw;
         end
      end
   endtask

   task automatic check_word(input string tag, input logic [N-1:0] cw);
      logic [NSYN*M-1:0] e;
      e = model(cw);
      chk({tag, "_syn"}, 128'(syndromes), 128'(e));
      chk({tag, "_err"}, 128'(error), 128'(|e));
   endtask

   initial begin
      logic [N-1:0] w_zero, w_ones, w_third, w_x0, w_x1, w_x254, w_two, w_fifth;
      logic [NSYN*M-1:0] snap;
      int lat, rb;

      alog[0] = 8'h01;
      for (int i = 1; i < int'(N); i++) alog[i] = gf_mul(alog[i-1], 8'h02);

      w_zero  = '0;
      w_ones  = '1;
      w_third = '0;
      for (int i = 0; i < int'(N); i += 3) w_third[i] = 1'b1;
      w_fifth = '0;
      for (int i = 0; i < int'(N); i += 5) w_fifth[i] = 1'b1;
      w_x0   = N'(1);
      w_x1   = N'(1) << 1;
      w_x254 = N'(1) << 254;
      w_two  = (N'(1) << 200) | (N'(1) << 17);

      rst = 1'b1;
      start = 1'b0;
      codeword = '0;
      #1;
      chk("rst_ready", 128'(ready), 128'(1));
      chk("rst_done",  128'(done), 128'(0));
      chk("rst_err",   128'(error), 128'(0));
      chk("rst_syn",   128'(syndromes), 128'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      run_word(w_zero, -1, '0, lat, rb);
      chk("zero_lat", 128'(lat), 128'(256));
      chk("zero_syn", 128'(syndromes), 128'(0));
      chk("zero_err", 128'(error), 128'(0));
      chk("zero_rdy_busy", 128'(rb), 128'(0));

      // All-ones and period-3/5 words are multiples of g(x): zero syndromes.
      @(negedge clk);
      run_word(w_ones, -1, '0, lat, rb);
      chk("ones_syn", 128'(syndromes), 128'(0));
      chk("ones_err", 128'(error), 128'(0));
      @(negedge clk);
      run_word(w_third, -1, '0, lat, rb);
      check_word("third", w_third);
      @(negedge clk);
      run_word(w_fifth, -1, '0, lat, rb);
      check_word("fifth", w_fifth);

      @(negedge clk);
      run_word(w_x0, -1, '0, lat, rb);
      chk("x0_syn", 128'(syndromes), {16{8'h01}});
      chk("x0_err", 128'(error), 128'(1));

      @(negedge clk);
      run_word(w_x1, -1, '0, lat, rb);
      chk("x1_s1", 128'(syndromes[0*M +: M]), 128'(8'h02));
      chk("x1_s2", 128'(syndromes[1*M +: M]), 128'(8'h04));
      chk("x1_s4", 128'(syndromes[3*M +: M]), 128'(8'h10));
      chk("x1_s8", 128'(syndromes[7*M +: M]), 128'(8'h1D));
      check_word("x1", w_x1);
      snap = syndromes;
      repeat (3) @(negedge clk);
      chk("hold_syn", 128'(syndromes), 128'(snap));
      chk("hold_err", 128'(error), 128'(1));
      chk("idle_ready", 128'(ready), 128'(1));
      chk("idle_done", 128'(done), 128'(0));

      @(negedge clk);
      run_word(w_x254, -1, '0, lat, rb);
      chk("x254_s1", 128'(syndromes[0*M +: M]), 128'(8'h8E));
      check_word("x254", w_x254);

      @(negedge clk);
      run_word(w_two, -1, '0, lat, rb);
      check_word("two", w_two);

      // Start pulse mid-run must be ignored.
      @(negedge clk);
      run_word(w_x1, 50, w_x254, lat, rb);
      chk("ign_lat", 128'(lat), 128'(256));
      chk("ign_rdy_busy", 128'(rb), 128'(0));
      check_word("ign", w_x1);
      @(negedge clk);
      chk("ign_no_restart", 128'(ready), 128'(1));

      // Back-to-back: start in the done cycle.
      @(negedge clk);
      run_word(w_x0, -1, '0, lat, rb);
      chk("b2b_ready_done", 128'(ready), 128'(1));
      run_word(w_x254, -1, '0, lat, rb);
      chk("b2b_lat", 128'(lat), 128'(256));
      check_word("b2b", w_x254);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      start = 1'b1;
      codeword = w_x254;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (100) @(negedge clk);
      chk("mid_busy", 128'(ready), 128'(0));
      chk("mid_nonzero", 128'(syndromes != '0), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("arst_ready", 128'(ready), 128'(1));
      chk("arst_syn",   128'(syndromes), 128'(0));
      chk("arst_done",  128'(done), 128'(0));
      chk("arst_err",   128'(error), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_word(w_ones, -1, '0, lat, rb);
      chk("post_rst_lat", 128'(lat), 128'(256));
      chk("post_rst_syn", 128'(syndromes), 128'(0));
      chk("post_rst_err", 128'(error), 128'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
